// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit: forward selects, FSM states, x0 index.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MC_BUSY = 1'b1
  } hz_state_t;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Per-source-port forwarding match: mem beats writeback, x0 is never forwarded.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_valid,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_we,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_we,
  output fwd_sel_t          sel
);

  logic m_hit;
  logic w_hit;

  always_comb begin
    m_hit = rs_valid && m_we && (m_rd == rs) && (m_rd != REG_AW'(X0));
    w_hit = rs_valid && w_we && (w_rd == rs) && (w_rd != REG_AW'(X0));
    sel   = FWD_NONE;
    if (m_hit) begin
      sel = FWD_MEM;
    end else if (w_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 core: forwarding, load-use, multi-cycle sequencing, redirect.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MC_LAT  = 4,
  parameter int PERF_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] D_rs,
  input  logic [NUM_SRC-1:0]        D_rs_valid,
  input  logic [NUM_SRC*REG_AW-1:0] E_rs,
  input  logic [NUM_SRC-1:0]        E_rs_valid,
  input  logic [REG_AW-1:0]         E_rd,
  input  logic                      E_we,
  input  logic                      E_is_load,
  input  logic                      E_is_mc,
  input  logic                      E_redirect,
  input  logic [REG_AW-1:0]         M_rd,
  input  logic                      M_we,
  input  logic [REG_AW-1:0]         W_rd,
  input  logic                      W_we,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_F,
  output logic                      stall_D,
  output logic                      stall_E,
  output logic                      flush_D,
  output logic                      flush_E,
  output logic                      flush_M,
  output logic                      mc_busy,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0]         perf_stall_cyc,
  output logic [PERF_W-1:0]         perf_flush_cnt,
  output logic [PERF_W-1:0]         perf_fwd_cnt,
`endif
  output hz_state_t                 dbg_state
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  hz_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 lu_hit, load_use, run, mc_enter, redirect, mc_hold, lu_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel_t sel;
    fwd_match #(.REG_AW(REG_AW)) u_fwd_match (
      .rs       (E_rs[i*REG_AW +: REG_AW]),
      .rs_valid (E_rs_valid[i]),
      .m_rd     (M_rd),
      .m_we     (M_we),
      .w_rd     (W_rd),
      .w_we     (W_we),
      .sel      (sel)
    );
    assign fwd_raw[i*2 +: 2] = sel;
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (D_rs_valid[i] && (D_rs[i*REG_AW +: REG_AW] == E_rd)) lu_hit = 1'b1;
    end
    load_use = E_is_load && E_we && (E_rd != REG_AW'(X0)) && lu_hit;
    run      = (state_q == HZ_RUN);
    mc_enter = run && E_is_mc && !E_redirect;
    redirect = run && E_redirect;
    // Stalls hold through the last counted cycle; the cnt==0 cycle lets E advance.
    mc_hold  = mc_enter || ((state_q == HZ_MC_BUSY) && (cnt_q != '0));
    lu_stall = run && load_use && !redirect && !mc_enter;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_RUN: begin
        if (mc_enter) begin
          state_d = HZ_MC_BUSY;
          cnt_d   = CNT_W'(MC_LAT - 2);
        end
      end
      HZ_MC_BUSY: begin
        if (cnt_q == '0) state_d = HZ_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = HZ_RUN;
    endcase

    fwd_sel = rst_n ? fwd_raw : '0;
    stall_F = rst_n && (mc_hold || lu_stall);
    stall_D = rst_n && (mc_hold || lu_stall);
    stall_E = rst_n && mc_hold;
    flush_M = rst_n && mc_hold;
    mc_busy = rst_n && mc_hold;
    flush_D = rst_n && redirect;
    flush_E = rst_n && (redirect || lu_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating increments: a counter sticks at all-ones once it gets there.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_F && !(&stall_cyc_q))         stall_cyc_d = stall_cyc_q + 1'b1;
    if (flush_D && !(&flush_cnt_q))         flush_cnt_d = flush_cnt_q + 1'b1;
    if ((|fwd_sel) && !(&fwd_cnt_q))        fwd_cnt_d   = fwd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, x0, load-use, multi-cycle, redirect, reset.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int MC_LAT  = 4;
  localparam int PERF_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC*REG_AW-1:0] D_rs, E_rs;
  logic [NUM_SRC-1:0]        D_rs_valid, E_rs_valid;
  logic [REG_AW-1:0]         E_rd, M_rd, W_rd;
  logic                      E_we, E_is_load, E_is_mc, E_redirect, M_we, W_we;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_busy;
  hz_state_t                 dbg_state;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0]         perf_stall_cyc, perf_flush_cnt, perf_fwd_cnt;
`endif

  int checks;
  int errors;

  // {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_busy}
  logic [6:0] ctrl;
  assign ctrl = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_busy};

  hazard_ctrl #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW),
    .MC_LAT  (MC_LAT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .D_rs           (D_rs),
    .D_rs_valid     (D_rs_valid),
    .E_rs           (E_rs),
    .E_rs_valid     (E_rs_valid),
    .E_rd           (E_rd),
    .E_we           (E_we),
    .E_is_load      (E_is_load),
    .E_is_mc        (E_is_mc),
    .E_redirect     (E_redirect),
    .M_rd           (M_rd),
    .M_we           (M_we),
    .W_rd           (W_rd),
    .W_we           (W_we),
    .fwd_sel        (fwd_sel),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .flush_M        (flush_M),
    .mc_busy        (mc_busy),
`ifdef HAZARD_PERF_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    D_rs = '0; D_rs_valid = '0; E_rs = '0; E_rs_valid = '0;
    E_rd = '0; E_we = 1'b0; E_is_load = 1'b0; E_is_mc = 1'b0; E_redirect = 1'b0;
    M_rd = '0; M_we = 1'b0; W_rd = '0; W_we = 1'b0;
  endtask

  // Move to 1 ns after the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    E_is_mc = 1'b1; E_rs = {5'd0, 5'd3}; E_rs_valid = 2'b01; M_we = 1'b1; M_rd = 5'd3;
    #12;
    checks++;
    if (ctrl !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, 7'b0);
    end
    checks++;
    if (fwd_sel !== 4'b0) begin
      errors++; $display("FAIL reset_fwd got %b want %b", fwd_sel, 4'b0);
    end
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();
    checks++;
    if (dbg_state !== HZ_RUN || ctrl !== 7'b0) begin
      errors++; $display("FAIL reset_release got state %0d ctrl %b want 0 0000000", dbg_state, ctrl);
    end
  endtask

  task automatic test_forward();
    idle_inputs();
    E_rs = {5'd0, 5'd5}; E_rs_valid = 2'b01;
    M_we = 1'b1; M_rd = 5'd5; W_we = 1'b1; W_rd = 5'd5;
    #1;
    checks++;
    if (fwd_sel !== 4'b0001) begin
      errors++; $display("FAIL fwd_mem_prio got %b want %b", fwd_sel, 4'b0001);
    end
    M_we = 1'b0;
    #1;
    checks++;
    if (fwd_sel !== 4'b0010) begin
      errors++; $display("FAIL fwd_wb got %b want %b", fwd_sel, 4'b0010);
    end
    // Port 1 from mem, port 0 from wb; invalid ports must not forward.
    E_rs = {5'd9, 5'd4}; E_rs_valid = 2'b11; M_we = 1'b1; M_rd = 5'd9; W_rd = 5'd4;
    #1;
    checks++;
    if (fwd_sel !== 4'b0110) begin
      errors++; $display("FAIL fwd_two_ports got %b want %b", fwd_sel, 4'b0110);
    end
    E_rs_valid = 2'b00;
    #1;
    checks++;
    if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL fwd_invalid got %b want %b", fwd_sel, 4'b0000);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    idle_inputs();
    E_rs = {5'd0, 5'd0}; E_rs_valid = 2'b10;
    M_we = 1'b1; M_rd = 5'd0; W_we = 1'b1; W_rd = 5'd0;
    #1;
    checks++;
    if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0 got %b want %b", fwd_sel, 4'b0000);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    idle_inputs();
    E_is_load = 1'b1; E_we = 1'b1; E_rd = 5'd7;
    D_rs = {5'd7, 5'd1}; D_rs_valid = 2'b10;
    #1;
    checks++;
    if (ctrl !== 7'b1100100) begin
      errors++; $display("FAIL load_use got %b want %b", ctrl, 7'b1100100);
    end
    next_cycle();
    E_is_load = 1'b0; E_we = 1'b0; E_rd = '0;
    #1;
    checks++;
    if (ctrl !== 7'b0) begin
      errors++; $display("FAIL load_use_after got %b want %b", ctrl, 7'b0);
    end
    // Matching register but source not read: no hazard.
    E_is_load = 1'b1; E_we = 1'b1; E_rd = 5'd7; D_rs_valid = 2'b01;
    #1;
    checks++;
    if (ctrl !== 7'b0) begin
      errors++; $display("FAIL load_use_invalid got %b want %b", ctrl, 7'b0);
    end
    next_cycle();
  endtask

  task automatic test_multicycle();
    logic [6:0] exp_seq [4];
    exp_seq[0] = 7'b1110011; exp_seq[1] = 7'b1110011;
    exp_seq[2] = 7'b1110011; exp_seq[3] = 7'b0000000;
    idle_inputs();
    E_is_mc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ctrl !== exp_seq[c]) begin
        errors++; $display("FAIL mc_cycle%0d got %b want %b", c + 1, ctrl, exp_seq[c]);
      end
      next_cycle();
    end
    E_is_mc = 1'b0;
    #1;
    checks++;
    if (dbg_state !== HZ_RUN || ctrl !== 7'b0) begin
      errors++; $display("FAIL mc_done got state %0d ctrl %b want 0 0000000", dbg_state, ctrl);
    end
    next_cycle();

    // Reset on the second cycle of the op.
    E_is_mc = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 7'b0 || dbg_state !== HZ_RUN) begin
      errors++; $display("FAIL mc_reset got state %0d ctrl %b want 0 0000000", dbg_state, ctrl);
    end
    E_is_mc = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    checks++;
    if (ctrl !== 7'b0 || dbg_state !== HZ_RUN) begin
      errors++; $display("FAIL mc_reset_release got state %0d ctrl %b want 0 0000000", dbg_state, ctrl);
    end
  endtask

  task automatic test_redirect();
    idle_inputs();
    E_redirect = 1'b1;
    E_is_load = 1'b1; E_we = 1'b1; E_rd = 5'd7; D_rs = {5'd0, 5'd7}; D_rs_valid = 2'b01;
    #1;
    checks++;
    if (ctrl !== 7'b0001100) begin
      errors++; $display("FAIL redirect_lu got %b want %b", ctrl, 7'b0001100);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_flush_before got %0d want 0", perf_flush_cnt);
    end
`endif
    next_cycle();
    idle_inputs();
    #1;
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_flush_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_flush_after got %0d want 1", perf_flush_cnt);
    end
`endif
    checks++;
    if (ctrl !== 7'b0) begin
      errors++; $display("FAIL redirect_after got %b want %b", ctrl, 7'b0);
    end
    next_cycle();
  endtask

  task automatic test_redirect_in_mc();
    logic [6:0] exp_seq [4];
    exp_seq[0] = 7'b1110011; exp_seq[1] = 7'b1110011;
    exp_seq[2] = 7'b1110011; exp_seq[3] = 7'b0000000;
    idle_inputs();
    E_is_mc = 1'b1;
    for (int c = 0; c < 4; c++) begin
      E_redirect = (c == 1) || (c == 2);
      E_is_load = (c == 1); E_we = (c == 1); E_rd = 5'd3;
      D_rs = {5'd3, 5'd0}; D_rs_valid = 2'b10;
      #1;
      checks++;
      if (ctrl !== exp_seq[c]) begin
        errors++; $display("FAIL mc_redirect_cycle%0d got %b want %b", c + 1, ctrl, exp_seq[c]);
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (dbg_state !== HZ_RUN) begin
      errors++; $display("FAIL mc_redirect_state got %0d want %0d", dbg_state, HZ_RUN);
    end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forward();
    test_x0();
    test_load_use();
    test_multicycle();
    test_redirect();
    test_redirect_in_mc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
